// File: rtl/imem_arbiter.sv
// Arbitrates the instruction ROM read port between CPU fetch (priority) and a debug reader.
// A starvation counter forces a debug grant after MAX_WAIT eligible cycles.
module imem_arbiter #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic [AW-1:0] cpu_addr,
  output logic          cpu_stall,
  output logic          cpu_valid,
  output logic [DW-1:0] cpu_inst,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_data,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_inst
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {IDLE, DBG_PEND} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_t;

  state_t        state, state_next;
  owner_t        own_q, own_next;
  logic [CW-1:0] wait_cnt;
  logic [DW-1:0] dbg_data_q;
  logic          dbg_elig, dbg_gnt, cpu_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (state == IDLE && dbg_gnt) state_next = DBG_PEND;
  end

  // A request still held during DBG_PEND is not eligible, so the CPU always wins there.
  always_comb begin
    dbg_elig  = dbg_req && (state == IDLE);
    dbg_gnt   = dbg_elig && (!cpu_req || wait_cnt == WAIT_LAST);
    cpu_gnt   = cpu_req && !dbg_gnt;
    cpu_stall = cpu_req && !cpu_gnt;
    rom_addr  = dbg_gnt ? dbg_addr : cpu_addr;
    own_next  = OWN_NONE;
    if (dbg_gnt)      own_next = OWN_DBG;
    else if (cpu_gnt) own_next = OWN_CPU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      own_q      <= OWN_NONE;
      wait_cnt   <= '0;
      dbg_data_q <= '0;
    end else begin
      own_q <= own_next;
      if (dbg_gnt || !dbg_req)
        wait_cnt <= '0;
      else if (dbg_elig && wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + CW'(1);
      if (own_q == OWN_DBG)
        dbg_data_q <= rom_inst;
    end
  end

  assign cpu_valid = (own_q == OWN_CPU);
  assign dbg_ack   = (own_q == OWN_DBG);
  assign cpu_inst  = cpu_valid ? rom_inst : '0;
  assign dbg_data  = dbg_ack ? rom_inst : dbg_data_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter with a one-cycle-latency ROM model (MAX_WAIT=4).
`timescale 1ns/100ps
module tb_imem_arbiter;

  localparam int AW = 30;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic          cpu_stall, cpu_valid, dbg_ack;
  logic [DW-1:0] cpu_inst, dbg_data, rom_inst;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [AW-1:0] rom_addr;
  logic [AW-1:0] rom_addr_q = '0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] dbg_q[$];

  imem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
    .cpu_valid(cpu_valid), .cpu_inst(cpu_inst),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data),
    .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  always #5 clk = ~clk;

  // ROM: registers the address, data valid the following cycle.
  function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
    case (a)
      30'h0:   romWord = 32'h3c1d1000;
      30'h1:   romWord = 32'h0c001403;
      30'h2:   romWord = 32'h37bd7000;
      30'h3:   romWord = 32'h27bdffb8;
      30'h13:  romWord = 32'h240e0001;
      default: romWord = 32'he0000000 | {2'b00, a};
    endcase
  endfunction

  always @(posedge clk) rom_addr_q <= rom_addr;
  assign rom_inst = romWord(rom_addr_q);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of requests, checks the combinational decision, queues expected responses.
  task automatic applyStimulus(input logic cr, input logic [AW-1:0] ca,
                               input logic dr, input logic [AW-1:0] da,
                               input logic exp_stall, input logic [AW-1:0] exp_rom,
                               input logic push_cpu, input logic [DW-1:0] cpu_exp,
                               input logic push_dbg, input logic [DW-1:0] dbg_exp);
    @(posedge clk);
    #1;
    cpu_req = cr; cpu_addr = ca; dbg_req = dr; dbg_addr = da;
    #1;
    checkOutput("cpu_stall", {31'b0, cpu_stall}, {31'b0, exp_stall});
    checkOutput("rom_addr", {2'b00, rom_addr}, {2'b00, exp_rom});
    if (push_cpu) cpu_q.push_back(cpu_exp);
    if (push_dbg) dbg_q.push_back(dbg_exp);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cpu_valid"}, {31'b0, cpu_valid}, 32'h0);
    checkOutput({tag, "_dbg_ack"}, {31'b0, dbg_ack}, 32'h0);
    checkOutput({tag, "_cpu_inst"}, cpu_inst, 32'h0);
    checkOutput({tag, "_dbg_data"}, dbg_data, 32'h0);
  endtask

  // Monitor: pops an expectation whenever the DUT presents a response.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cpu_valid) begin
          if (cpu_q.size() == 0) checkOutput("cpu_unexpected_valid", 32'h1, 32'h0);
          else checkOutput("cpu_inst", cpu_inst, cpu_q.pop_front());
        end
        if (dbg_ack) begin
          if (dbg_q.size() == 0) checkOutput("dbg_unexpected_ack", 32'h1, 32'h0);
          else checkOutput("dbg_data", dbg_data, dbg_q.pop_front());
        end
      end
    end
  end

  initial begin
    #3;
    checkResetOutputs("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // CPU stream, one fetch per cycle
    applyStimulus(1, 30'h0, 0, 30'h0, 0, 30'h0, 1, 32'h3c1d1000, 0, 0);
    applyStimulus(1, 30'h1, 0, 30'h0, 0, 30'h1, 1, 32'h0c001403, 0, 0);
    applyStimulus(1, 30'h2, 0, 30'h0, 0, 30'h2, 1, 32'h37bd7000, 0, 0);
    applyStimulus(1, 30'h3, 0, 30'h0, 0, 30'h3, 1, 32'h27bdffb8, 0, 0);

    // Reset asserted while a CPU response is on the outputs; that response is dropped
    applyStimulus(1, 30'h4, 0, 30'h0, 0, 30'h4, 0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("pre_reset_cpu_valid", {31'b0, cpu_valid}, 32'h1);
    rst_n = 1'b0; cpu_req = 1'b0;
    #1 checkResetOutputs("mid");
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(1, 30'h0, 0, 30'h0, 0, 30'h0, 1, 32'h3c1d1000, 0, 0);

    // Debug alone, then hold of dbg_data after request drops
    applyStimulus(0, 30'h0, 1, 30'h2, 0, 30'h2, 0, 0, 1, 32'h37bd7000);
    applyStimulus(0, 30'h0, 0, 30'h2, 0, 30'h0, 0, 0, 0, 0);
    applyStimulus(0, 30'h0, 0, 30'h2, 0, 30'h0, 0, 0, 0, 0);
    checkOutput("dbg_data_hold", dbg_data, 32'h37bd7000);

    // Starvation with MAX_WAIT=4: forced grant on the fourth eligible cycle
    applyStimulus(1, 30'h4, 1, 30'h13, 0, 30'h4, 1, 32'he0000004, 0, 0);
    applyStimulus(1, 30'h5, 1, 30'h13, 0, 30'h5, 1, 32'he0000005, 0, 0);
    applyStimulus(1, 30'h6, 1, 30'h13, 0, 30'h6, 1, 32'he0000006, 0, 0);
    applyStimulus(1, 30'h7, 1, 30'h13, 1, 30'h13, 0, 0, 1, 32'h240e0001);
    applyStimulus(1, 30'h7, 0, 30'h13, 0, 30'h7, 1, 32'he0000007, 0, 0);
    applyStimulus(0, 30'h0, 0, 30'h0, 0, 30'h0, 0, 0, 0, 0);

    // Request held through its ack cycle with a new address
    applyStimulus(0, 30'h9, 1, 30'h1, 0, 30'h1, 0, 0, 1, 32'h0c001403);
    applyStimulus(1, 30'h2, 1, 30'h3, 0, 30'h2, 1, 32'h37bd7000, 0, 0);
    applyStimulus(0, 30'h9, 1, 30'h3, 0, 30'h3, 0, 0, 1, 32'h27bdffb8);
    applyStimulus(0, 30'h9, 0, 30'h3, 0, 30'h9, 0, 0, 0, 0);
    applyStimulus(0, 30'h9, 0, 30'h3, 0, 30'h9, 0, 0, 0, 0);

    // Reset during the ack cycle: the outstanding read is dropped silently
    applyStimulus(0, 30'h9, 1, 30'h13, 0, 30'h13, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; dbg_req = 1'b0;
    #1 checkResetOutputs("pend");
    @(posedge clk); #1 rst_n = 1'b1;
    applyStimulus(0, 30'h9, 1, 30'h13, 0, 30'h13, 0, 0, 1, 32'h240e0001);
    applyStimulus(0, 30'h9, 0, 30'h13, 0, 30'h9, 0, 0, 0, 0);

    for (int i = 0; i < 10 && (cpu_q.size() != 0 || dbg_q.size() != 0); i++)
      @(posedge clk);
    checkOutput("cpu_queue_drained", cpu_q.size(), 32'h0);
    checkOutput("dbg_queue_drained", dbg_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
